bcd_serial_addsub: RTL and testbench

Digit-serial BCD adder/subtractor for multi-digit operands. Operand digit pairs arrive one per cycle, least-significant digit (LSD) first, over a valid/ready stream. Each result digit leaves one cycle later with carry or borrow chained across the word. Single-digit words reproduce the mod-10 add/subtract behaviour of the combinational digit adder. The block sits between the operand source and the result consumer as the sequenced datapath.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_addsub.sv | 52 +++++
 rtl/bcd_serial_addsub.sv | 160 ++++++++++++++++
 tb/tb_bcd_serial_addsub.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder/subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } addsub_state_t;

    localparam int   BCD_RADIX = 10;
    localparam logic OP_ADD    = 1'b0;
    localparam logic OP_SUB    = 1'b1;

endpackage

// File: rtl/bcd_digit_addsub.sv
// Single BCD digit add/subtract with carry/borrow in and out.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
//
// Ports:
//   x, y  : operand digits (BCD 0..9; other codes give a deterministic result)
//   cin   : incoming carry (add) or borrow (sub)
//   op    : OP_ADD or OP_SUB (x - y)
//   z     : result digit
//   cout  : outgoing carry (add) or borrow (sub)
module bcd_digit_addsub
    import bcd_pkg::*;
(
    input  bcd_digit_t x,
    input  bcd_digit_t y,
    input  logic       cin,
    input  logic       op,
    output bcd_digit_t z,
    output logic       cout
);

    logic [4:0] w_sum;
    logic [4:0] w_diff;

    // Sum fits in 5 bits even for 15+15+1.
    assign w_sum  = {1'b0, x} + {1'b0, y} + {4'b0, cin};
    // Difference spans -16..15, so a 5-bit two's complement value holds it;
    // bit 4 is the sign.
    assign w_diff = {1'b0, x} - {1'b0, y} - {4'b0, cin};

    always_comb begin
        z    = '0;
        cout = 1'b0;
        if (op == OP_SUB) begin
            if (w_diff[4]) begin
                // Low nibble plus ten is the mod-16 image of t + 10.
                z    = w_diff[3:0] + 4'(BCD_RADIX);
                cout = 1'b1;
            end else begin
                z    = w_diff[3:0];
            end
        end else begin
            if (w_sum >= 5'(BCD_RADIX)) begin
                z    = w_sum[3:0] - 4'(BCD_RADIX);
                cout = 1'b1;
            end else begin
                z    = w_sum[3:0];
            end
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD add/sub, LSD first, carry/borrow chained across a word.
// Latency: one cycle from digit accept to result valid; 1 digit/cycle.
// Backpressure: single output register; in_ready = !out_valid || out_ready.
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   s                         : 0 add, 1 subtract; sampled on a word's first digit
//   in_valid/in_ready         : operand stream handshake
//   x_digit, y_digit, in_last : operand digits and most-significant-digit marker
//   out_valid/out_ready       : result stream handshake
//   z_digit, out_last         : result digit and word-end marker
//   out_carry                 : final carry/borrow, only nonzero with out_last
//   err                       : sticky invalid-digit flag (BCD_ADDSUB_CHECK_EN), else 0
//
// Optional feature macro: BCD_ADDSUB_CHECK_EN enables digit range checking.
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s,
    input  logic       in_valid,
    output logic       in_ready,
    input  bcd_digit_t x_digit,
    input  bcd_digit_t y_digit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output bcd_digit_t z_digit,
    output logic       out_last,
    output logic       out_carry,
    output logic       err
);

    localparam int CW = $clog2(NDIGITS + 1);

    addsub_state_t r_state;
    addsub_state_t w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_step;

    logic          r_op;
    logic          r_carry;
    logic          r_out_valid;
    bcd_digit_t    r_z;
    logic          r_out_last;
    logic          r_out_carry;

    logic          w_accept;
    logic          w_first;
    logic          w_op;
    logic          w_cin;
    logic          w_word_end;
    bcd_digit_t    w_core_z;
    logic          w_core_cout;
    bcd_digit_t    w_z;
    logic          w_cout;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_first   = (r_state == IDLE);

    // The first digit of a word takes the live op and a clean carry; later
    // digits use the latched values so mid-word changes of s are ignored.
    assign w_op      = w_first ? s    : r_op;
    assign w_cin     = w_first ? 1'b0 : r_carry;

    assign w_cnt_step = w_first ? CW'(1) : (r_cnt + CW'(1));
    assign w_word_end = in_last || (w_cnt_step == CW'(NDIGITS));

    bcd_digit_addsub u_core (
        .x    (x_digit),
        .y    (y_digit),
        .cin  (w_cin),
        .op   (w_op),
        .z    (w_core_z),
        .cout (w_core_cout)
    );

`ifdef BCD_ADDSUB_CHECK_EN
    logic w_bad;
    logic r_err;

    assign w_bad  = (x_digit > 4'(BCD_RADIX - 1)) || (y_digit > 4'(BCD_RADIX - 1));
    // A bad digit yields zero and does not propagate a carry/borrow.
    assign w_z    = w_bad ? '0   : w_core_z;
    assign w_cout = w_bad ? 1'b0 : w_core_cout;
    assign err    = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept && w_bad) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_z    = w_core_z;
    assign w_cout = w_core_cout;
    assign err    = 1'b0;
`endif

    // Word sequencing: a first digit that is also the last never leaves IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_accept) begin
            if (w_word_end) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = RUN;
                w_cnt_nxt   = w_cnt_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Datapath and output register. An accept overwrites the register even
    // when the current result is being drained, so streaming has no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= OP_ADD;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
            r_z         <= '0;
            r_out_last  <= 1'b0;
            r_out_carry <= 1'b0;
        end else if (w_accept) begin
            if (w_first) begin
                r_op <= s;
            end
            r_carry     <= w_cout;
            r_out_valid <= 1'b1;
            r_z         <= w_z;
            r_out_last  <= w_word_end;
            r_out_carry <= w_word_end && w_cout;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign z_digit   = r_z;
    assign out_last  = r_out_last;
    assign out_carry = r_out_carry;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub: directed and random words
// checked against a whole-number arithmetic reference model.
// Timing: inputs change 1 time unit after a rising edge, outputs sampled on falling edges.
module tb_bcd_serial_addsub;

    logic       clk = 1'b0;
    logic       rst;
    logic       s;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] x_digit;
    logic [3:0] y_digit;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] z_digit;
    logic       out_last;
    logic       out_carry;
    logic       err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [5:0] obs_q[$];
    int         wx[4];
    int         wy[4];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every result digit that is handed over at the next rising edge.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1)
            obs_q.push_back({z_digit, out_last, out_carry});
    end

    bcd_serial_addsub #(.NDIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_digit   (x_digit),
        .y_digit   (y_digit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z_digit   (z_digit),
        .out_last  (out_last),
        .out_carry (out_carry),
        .err       (err)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one digit pair and hold it until it is accepted.
    task automatic send(input logic [3:0] xd, input logic [3:0] yd, input logic sv, input logic lst);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        x_digit  = xd;
        y_digit  = yd;
        s        = sv;
        in_last  = lst;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        chk("accept", 32'(ok), 32'd1);
    endtask

    // Send wx/wy[0..n-1]; s is randomised after the first digit to show it is ignored.
    task automatic send_word(input int n, input logic op, input logic give_last);
        for (int i = 0; i < n; i++) begin
            send(4'(wx[i]), 4'(wy[i]),
                 (i == 0) ? op : 1'($urandom_range(0, 1)),
                 give_last && (i == n - 1));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Reference: treat the digits as whole decimal numbers and do the arithmetic modulo 10^n.
    task automatic check_word(input int n, input logic op, input string tag);
        longint xv, yv, m, r;
        bit c;
        bit got;
        logic [5:0] e;
        logic [5:0] o;
        xv = 0; yv = 0; m = 1;
        for (int i = 0; i < n; i++) begin
            xv += longint'(wx[i]) * m;
            yv += longint'(wy[i]) * m;
            m  *= 10;
        end
        if (op == 1'b0) begin
            r = xv + yv;
            c = (r >= m);
            if (c) r -= m;
        end else begin
            r = xv - yv;
            c = (r < 0);
            if (c) r += m;
        end
        for (int k = 0; k < 60 && obs_q.size() < n; k++) begin
            @(posedge clk);
            #1;
        end
        got = (obs_q.size() >= n);
        chk({tag, "_count"}, 32'(got), 32'd1);
        if (got) begin
            for (int i = 0; i < n; i++) begin
                e = {4'(r % 10), 1'(i == n - 1), 1'((i == n - 1) && c)};
                r = r / 10;
                o = obs_q.pop_front();
                chk($sformatf("%s_d%0d", tag, i), 32'(o), 32'(e));
            end
        end
    endtask

    initial begin
        int c0;
        int n;
        logic op;

        rst       = 1'b1;
        s         = 1'b0;
        in_valid  = 1'b0;
        x_digit   = 4'd0;
        y_digit   = 4'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state (out_ready low so in_ready depends only on out_valid).
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_z",         32'(z_digit),   32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_out_carry", 32'(out_carry), 32'd0);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Every single-digit word.
        for (int sv = 0; sv < 2; sv++) begin
            for (int xi = 0; xi < 10; xi++) begin
                for (int yi = 0; yi < 10; yi++) begin
                    wx[0] = xi;
                    wy[0] = yi;
                    send_word(1, 1'(sv), 1'b1);
                    check_word(1, 1'(sv), "single");
                end
            end
        end

        // 0999 + 0001, streamed at full rate.
        wx = '{9, 9, 9, 0};
        wy = '{1, 0, 0, 0};
        c0 = cyc;
        send_word(4, 1'b0, 1'b1);
        chk("add_rate", 32'(cyc - c0), 32'd4);
        check_word(4, 1'b0, "add0999");

        // 0100 - 0001 and 0000 - 0001.
        wx = '{0, 0, 1, 0};
        wy = '{1, 0, 0, 0};
        send_word(4, 1'b1, 1'b1);
        check_word(4, 1'b1, "sub0100");
        wx = '{0, 0, 0, 0};
        wy = '{1, 0, 0, 0};
        send_word(4, 1'b1, 1'b1);
        check_word(4, 1'b1, "sub0000");

        // Backpressure mid-word: 4372 + 2185.
        wx = '{2, 7, 3, 4};
        wy = '{5, 8, 1, 2};
        send(4'd2, 4'd5, 1'b0, 1'b0);
        send(4'd7, 4'd8, 1'b1, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        x_digit   = 4'd3;
        y_digit   = 4'd1;
        in_last   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready),  32'd0);
            chk("bp_valid",    32'(out_valid), 32'd1);
            chk("bp_z_hold",   32'(z_digit),   32'd5);
            chk("bp_last",     32'(out_last),  32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        c0 = cyc;
        send(4'd3, 4'd1, 1'b0, 1'b0);
        send(4'd4, 4'd2, 1'b1, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bp_rate", 32'(cyc - c0), 32'd2);
        check_word(4, 1'b0, "bp");

        // Forced last at NDIGITS, then a fresh word must start with carry 0.
        wx = '{9, 9, 9, 9};
        wy = '{1, 0, 0, 0};
        send_word(4, 1'b0, 1'b0);
        check_word(4, 1'b0, "forced");
        wx[0] = 3;
        wy[0] = 4;
        send_word(1, 1'b0, 1'b1);
        check_word(1, 1'b0, "after_forced");

        // Reset after two digits of a word.
        send(4'd9, 4'd9, 1'b0, 1'b0);
        send(4'd9, 4'd9, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        obs_q.delete();
        wx = '{2, 1, 0, 0};
        wy = '{5, 0, 0, 0};
        send_word(2, 1'b1, 1'b1);
        check_word(2, 1'b1, "after_rst");

        // Random words, including some that end by the digit limit.
        for (int w = 0; w < 40; w++) begin
            n  = $urandom_range(1, 4);
            op = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                wx[i] = $urandom_range(0, 9);
                wy[i] = $urandom_range(0, 9);
            end
            send_word(n, op, (n < 4) ? 1'b1 : 1'($urandom_range(0, 1)));
            check_word(n, op, "rand");
        end

`ifdef BCD_ADDSUB_CHECK_EN
        send(4'd12, 4'd3, 1'b0, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        chk("bad_z",   32'(z_digit), 32'd0);
        chk("bad_err", 32'(err),     32'd1);
        @(posedge clk);
        #1;
        obs_q.delete();
        wx[0] = 2;
        wy[0] = 3;
        send_word(1, 1'b0, 1'b1);
        check_word(1, 1'b0, "post_bad");
        @(negedge clk);
        chk("err_sticky", 32'(err), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("err_cleared", 32'(err), 32'd0);
`else
        send(4'd12, 4'd3, 1'b0, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        chk("err_tied", 32'(err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
